reg_file_raw: RTL and testbench

- Decode/operand-fetch stage directly upstream of the ALU operand mux: 32x32 integer register file with a per-register pending-write scoreboard.
- Accepts decoded source/destination addresses, stalls decode while a source or destination register has an outstanding write, and bypasses same-cycle writeback data.
- Presents registered operands to the next stage; RAW_rs2_val feeds the ALU operand mux.

---
 rtl/reg_file_raw.sv | 112 +++++++++++
 tb/tb_reg_file_raw.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_raw.sv
// Operand-fetch stage: 32x32 register file with a pending-write scoreboard.
// It stalls decode on RAW/WAW hazards and bypasses same-cycle writeback data.
module reg_file_raw #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int AW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            DCR_valid,
   input  logic [AW-1:0]   DCR_rs1_addr,
   input  logic [AW-1:0]   DCR_rs2_addr,
   input  logic [AW-1:0]   DCR_rd_addr,
   input  logic            DCR_rd_wen,
   output logic            DCR_ready,
   input  logic            WB_wr_en,
   input  logic [AW-1:0]   WB_rd_addr,
   input  logic [XLEN-1:0] WB_rd_val,
   output logic            RAW_valid,
   output logic [XLEN-1:0] RAW_rs1_val,
   output logic [XLEN-1:0] RAW_rs2_val,
   output logic            RAW_stall,
   output logic [NREG-1:0] TRACE_pending
);

   logic [XLEN-1:0] r_regs [NREG];
   logic [NREG-1:0] r_pending;

   logic            w_wbHit;
   logic [NREG-1:0] w_wbMask;
   logic [NREG-1:0] w_setMask;
   logic [NREG-1:0] w_pendEff;
   logic            w_stall;
   logic            w_issue;
   logic [XLEN-1:0] w_rs1Val;
   logic [XLEN-1:0] w_rs2Val;

   assign w_wbHit = WB_wr_en && (WB_rd_addr != '0);

   always_comb begin
      w_wbMask = '0;
      if (w_wbHit) begin
         w_wbMask[WB_rd_addr] = 1'b1;
      end
   end

   // A register being written back this cycle no longer blocks decode.
   assign w_pendEff = r_pending & ~w_wbMask;

   assign w_stall   = DCR_valid && (w_pendEff[DCR_rs1_addr] || w_pendEff[DCR_rs2_addr] ||
                                    (DCR_rd_wen && w_pendEff[DCR_rd_addr]));
   assign DCR_ready = !w_stall && !rst;
   assign w_issue   = DCR_valid && DCR_ready;

   always_comb begin
      w_setMask = '0;
      if (w_issue && DCR_rd_wen && (DCR_rd_addr != '0)) begin
         w_setMask[DCR_rd_addr] = 1'b1;
      end
   end

   function automatic logic [XLEN-1:0] readOperand(input logic [AW-1:0] addr);
      if (addr == '0) begin
         return '0;
      end else if (w_wbHit && (WB_rd_addr == addr)) begin
         return WB_rd_val;
      end else begin
         return r_regs[addr];
      end
   endfunction

   assign w_rs1Val = readOperand(DCR_rs1_addr);
   assign w_rs2Val = readOperand(DCR_rs2_addr);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wbHit) begin
         r_regs[WB_rd_addr] <= WB_rd_val;
      end
   end

   // Set beats clear when an issue re-targets a register being written back.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= '0;
      end else begin
         r_pending <= ((r_pending & ~w_wbMask) | w_setMask) & ~{{(NREG-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         RAW_valid   <= 1'b0;
         RAW_stall   <= 1'b0;
         RAW_rs1_val <= '0;
         RAW_rs2_val <= '0;
      end else begin
         RAW_valid <= w_issue;
         RAW_stall <= w_stall;
         if (w_issue) begin
            RAW_rs1_val <= w_rs1Val;
            RAW_rs2_val <= w_rs2Val;
         end
      end
   end

   assign TRACE_pending = r_pending;

endmodule

// File: tb/tb_reg_file_raw.sv
// Directed self-checking bench for reg_file_raw: hazards, bypass, x0 and reset.
module tb_reg_file_raw;

   logic        clk = 1'b0;
   logic        rst;
   logic        DCR_valid;
   logic [4:0]  DCR_rs1_addr;
   logic [4:0]  DCR_rs2_addr;
   logic [4:0]  DCR_rd_addr;
   logic        DCR_rd_wen;
   logic        DCR_ready;
   logic        WB_wr_en;
   logic [4:0]  WB_rd_addr;
   logic [31:0] WB_rd_val;
   logic        RAW_valid;
   logic [31:0] RAW_rs1_val;
   logic [31:0] RAW_rs2_val;
   logic        RAW_stall;
   logic [31:0] TRACE_pending;

   int checkCount = 0;
   int errorCount = 0;

   reg_file_raw dut (
      .clk          (clk),
      .rst          (rst),
      .DCR_valid    (DCR_valid),
      .DCR_rs1_addr (DCR_rs1_addr),
      .DCR_rs2_addr (DCR_rs2_addr),
      .DCR_rd_addr  (DCR_rd_addr),
      .DCR_rd_wen   (DCR_rd_wen),
      .DCR_ready    (DCR_ready),
      .WB_wr_en     (WB_wr_en),
      .WB_rd_addr   (WB_rd_addr),
      .WB_rd_val    (WB_rd_val),
      .RAW_valid    (RAW_valid),
      .RAW_rs1_val  (RAW_rs1_val),
      .RAW_rs2_val  (RAW_rs2_val),
      .RAW_stall    (RAW_stall),
      .TRACE_pending(TRACE_pending)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic wen,
                                input logic wb, input logic [4:0] wbAddr, input logic [31:0] wbVal);
      DCR_valid    = v;
      DCR_rs1_addr = rs1;
      DCR_rs2_addr = rs2;
      DCR_rd_addr  = rd;
      DCR_rd_wen   = wen;
      WB_wr_en     = wb;
      WB_rd_addr   = wbAddr;
      WB_rd_val    = wbVal;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      checkOutput("ready_in_reset", {31'b0, DCR_ready}, 32'd0);
      tick();
      tick();
      checkOutput("reset_valid", {31'b0, RAW_valid}, 32'd0);
      checkOutput("reset_rs1", RAW_rs1_val, 32'd0);
      checkOutput("reset_rs2", RAW_rs2_val, 32'd0);
      checkOutput("reset_stall", {31'b0, RAW_stall}, 32'd0);
      checkOutput("reset_pending", TRACE_pending, 32'd0);

      // First issue after reset
      rst = 1'b0;
      applyStimulus(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      checkOutput("first_ready", {31'b0, DCR_ready}, 32'd1);
      tick();
      checkOutput("first_valid", {31'b0, RAW_valid}, 32'd1);
      checkOutput("first_rs1", RAW_rs1_val, 32'd0);
      checkOutput("first_rs2", RAW_rs2_val, 32'd0);
      checkOutput("first_pending", TRACE_pending, 32'd0);

      // RAW hazard on x5, resolved by writeback bypass
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0);
      checkOutput("rd5_ready", {31'b0, DCR_ready}, 32'd1);
      tick();
      checkOutput("rd5_pending", TRACE_pending, 32'h0000_0020);
      applyStimulus(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      checkOutput("raw5_ready_a", {31'b0, DCR_ready}, 32'd0);
      tick();
      checkOutput("raw5_valid_a", {31'b0, RAW_valid}, 32'd0);
      checkOutput("raw5_stall_a", {31'b0, RAW_stall}, 32'd1);
      checkOutput("raw5_ready_b", {31'b0, DCR_ready}, 32'd0);
      tick();
      checkOutput("raw5_valid_b", {31'b0, RAW_valid}, 32'd0);
      applyStimulus(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      checkOutput("raw5_ready_wb", {31'b0, DCR_ready}, 32'd1);
      tick();
      checkOutput("raw5_valid", {31'b0, RAW_valid}, 32'd1);
      checkOutput("raw5_rs1", RAW_rs1_val, 32'hDEAD_BEEF);
      checkOutput("raw5_stall_clr", {31'b0, RAW_stall}, 32'd0);
      checkOutput("raw5_pending", TRACE_pending, 32'd0);

      // Same-cycle bypass of a non-pending register
      applyStimulus(1'b1, 5'd5, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 32'h1234_5678);
      checkOutput("byp7_ready", {31'b0, DCR_ready}, 32'd1);
      tick();
      checkOutput("byp7_rs2", RAW_rs2_val, 32'h1234_5678);
      checkOutput("byp7_rs1", RAW_rs1_val, 32'hDEAD_BEEF);
      checkOutput("byp7_pending", TRACE_pending, 32'd0);

      // Idle cycle holds operands
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      tick();
      checkOutput("hold_valid", {31'b0, RAW_valid}, 32'd0);
      checkOutput("hold_rs1", RAW_rs1_val, 32'hDEAD_BEEF);
      checkOutput("hold_rs2", RAW_rs2_val, 32'h1234_5678);

      // Writeback clear and issue set on x9 in one cycle: set wins
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 5'd0, 32'h0);
      tick();
      checkOutput("rd9_pending", TRACE_pending, 32'h0000_0200);
      applyStimulus(1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b1, 5'd9, 32'hCAFE_0009);
      checkOutput("waw9_ready", {31'b0, DCR_ready}, 32'd1);
      tick();
      checkOutput("waw9_pending", TRACE_pending, 32'h0000_0200);
      checkOutput("waw9_rs1", RAW_rs1_val, 32'hCAFE_0009);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9, 32'h0000_0011);
      tick();
      checkOutput("wb9_pending", TRACE_pending, 32'd0);

      // x0 writes ignored, x0 reads zero, rd=0 never pending
      applyStimulus(1'b1, 5'd0, 5'd9, 5'd0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
      checkOutput("x0_ready", {31'b0, DCR_ready}, 32'd1);
      tick();
      checkOutput("x0_rs1", RAW_rs1_val, 32'd0);
      checkOutput("x0_rs2", RAW_rs2_val, 32'h0000_0011);
      checkOutput("x0_pending", TRACE_pending, 32'd0);
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
      tick();
      checkOutput("x0_reread", RAW_rs1_val, 32'd0);
      checkOutput("x0_stall", {31'b0, RAW_stall}, 32'd0);

      // Reset during a stall on x2
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 5'd0, 32'h0);
      tick();
      checkOutput("rd2_pending", TRACE_pending, 32'h0000_0004);
      applyStimulus(1'b1, 5'd2, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      checkOutput("raw2_ready", {31'b0, DCR_ready}, 32'd0);
      tick();
      rst = 1'b1;
      #1;
      checkOutput("rst_ready", {31'b0, DCR_ready}, 32'd0);
      tick();
      checkOutput("rst_valid", {31'b0, RAW_valid}, 32'd0);
      checkOutput("rst_rs1", RAW_rs1_val, 32'd0);
      checkOutput("rst_rs2", RAW_rs2_val, 32'd0);
      checkOutput("rst_stall", {31'b0, RAW_stall}, 32'd0);
      checkOutput("rst_pending", TRACE_pending, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_ready", {31'b0, DCR_ready}, 32'd1);
      tick();
      checkOutput("post_rst_valid", {31'b0, RAW_valid}, 32'd1);
      checkOutput("post_rst_rs1", RAW_rs1_val, 32'd0);
      checkOutput("post_rst_rs2", RAW_rs2_val, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
